debug_uart_tx_wb: RTL

DEBUG_UART_TX_WB -- requirements
Module: debug_uart_tx_wb

---
 rtl/debug_uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/debug_uart_tx_wb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/debug_uart_pkg.sv
// Shared register map, STATUS bit positions and serializer state encoding
// for the Wishbone debug UART transmitter.
package debug_uart_pkg;

    // Register offsets as decoded from wb_adr_i[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // STATUS register bit positions; the count field starts at STAT_COUNT
    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_COUNT = 4;

    // Serializer FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push when full and pop when empty
// are ignored. Read data is the current head entry (show-ahead).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and count update; pointers wrap naturally since DEPTH is 2**AW
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written so no reset
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/debug_uart_tx_wb.sv
// Wishbone-attached 8N1 debug UART transmitter: registered single-cycle
// responses, TX FIFO, programmable baud divisor and a serializer FSM.
module debug_uart_tx_wb
    import debug_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_RESET  = 433
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    output logic        uart_tx_o
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);

    logic          req;
    logic [1:0]    reg_sel;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;
    logic [15:0]   div_q, div_d;
    logic [31:0]   status;

    logic          fifo_push, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;

    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    logic          unused_bits;

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:1]};

    assign req        = wb_cyc_i & wb_stb_i;
    assign reg_sel    = wb_adr_i[3:2];
    assign wb_stall_o = 1'b0;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_dat_o   = dat_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (fifo_push),
        .data_i  (wb_dat_i[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // STATUS word assembly
    always_comb begin
        status                     = '0;
        status[STAT_FULL]          = fifo_full;
        status[STAT_EMPTY]         = fifo_empty;
        status[STAT_BUSY]          = (state_q != ST_IDLE);
        status[STAT_COUNT +: CW]   = fifo_count;
    end

    // Register decode: side effects happen in the request cycle, response next cycle.
    // A full FIFO rejects the byte even if the serializer pops in the same cycle.
    always_comb begin
        fifo_push = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = '0;
        div_d     = div_q;
        if (req) begin
            case (reg_sel)
                REG_TXDATA: begin
                    if (wb_we_i && wb_sel_i[0] && fifo_full) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d     = 1'b1;
                        fifo_push = wb_we_i & wb_sel_i[0];
                    end
                end
                REG_STATUS: begin
                    ack_d = 1'b1;
                    if (!wb_we_i) dat_d = status;
                end
                REG_BAUDDIV: begin
                    ack_d = 1'b1;
                    if (wb_we_i) div_d = wb_dat_i[15:0];
                    else         dat_d = {16'h0000, div_q};
                end
                REG_RSVD: err_d = 1'b1;
                default:  err_d = 1'b1;
            endcase
        end
    end

    // Bus response and divisor registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            div_q <= DIV_INIT;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
            div_q <= div_d;
        end
    end

    assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty;

    // Serializer next state; the divisor is reloaded at every bit start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    shift_d = fifo_data;
                    state_d = ST_START;
                    cnt_d   = div_q;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = div_q;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = div_q;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serializer state registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Line driver decoded from state so reset forces the line high immediately
    always_comb begin
        case (state_q)
            ST_START: uart_tx_o = 1'b0;
            ST_DATA:  uart_tx_o = shift_q[0];
            default:  uart_tx_o = 1'b1;
        endcase
    end

endmodule
